// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the datapath and a req/ack data-memory port.
// Optional define LSU_MISALIGN_TRAP_EN: misaligned half/word accesses finish without a memory request and raise misalign_o.

module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ld_en_i,
   input  logic              st_en_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              done_o,
   output logic              stall_o,
   output logic              misalign_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic              isStore_q, isStore_d;
   logic [1:0]        addrLow_q, addrLow_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              misalign_q, misalign_d;
   logic              memReq_q, memReq_d;
   logic              memWe_q, memWe_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [DATA_W-1:0] memWdata_q, memWdata_d;
   logic [3:0]        memBe_q, memBe_d;

   logic              start;
   logic              trap;
   logic [3:0]        beNew;
   logic [DATA_W-1:0] wdataNew;
   logic [7:0]        loadByte;
   logic [15:0]       loadHalf;
   logic [DATA_W-1:0] loadExt;

   assign start = ld_en_i || st_en_i;

   // Store lane steering: replicate the datum so any byte-enable pattern picks the right lanes.
   always_comb begin
      beNew    = 4'b1111;
      wdataNew = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            beNew    = 4'b0001 << addr_i[1:0];
            wdataNew = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            beNew    = 4'b0011 << {addr_i[1], 1'b0};
            wdataNew = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      case (funct3_i[1:0])
         2'b00:   trap = 1'b0;
         2'b01:   trap = addr_i[0];
         default: trap = (addr_i[1:0] != 2'b00);
      endcase
   end
`else
   assign trap = 1'b0;
`endif

   // Load extraction uses the address captured at access start, not the live ALU result.
   always_comb begin
      case (addrLow_q)
         2'd0:    loadByte = mem_rdata_i[7:0];
         2'd1:    loadByte = mem_rdata_i[15:8];
         2'd2:    loadByte = mem_rdata_i[23:16];
         default: loadByte = mem_rdata_i[31:24];
      endcase
      loadHalf = addrLow_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (funct3_q[1:0])
         2'b00:   loadExt = {{24{~funct3_q[2] & loadByte[7]}}, loadByte};
         2'b01:   loadExt = {{16{~funct3_q[2] & loadHalf[15]}}, loadHalf};
         default: loadExt = mem_rdata_i;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      isStore_d  = isStore_q;
      addrLow_d  = addrLow_q;
      funct3_d   = funct3_q;
      rdata_d    = rdata_q;
      misalign_d = misalign_q;
      memReq_d   = memReq_q;
      memWe_d    = memWe_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      memBe_d    = memBe_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               isStore_d = st_en_i;
               addrLow_d = addr_i[1:0];
               funct3_d  = funct3_i;
               if (trap) begin
                  state_d    = DONE;
                  misalign_d = 1'b1;
                  rdata_d    = '0;
               end else begin
                  state_d    = REQ;
                  memReq_d   = 1'b1;
                  memWe_d    = st_en_i;
                  memAddr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                  memBe_d    = st_en_i ? beNew : 4'b1111;
                  memWdata_d = st_en_i ? wdataNew : '0;
               end
            end
         end
         REQ: begin
            if (mem_ack_i) begin
               state_d    = DONE;
               misalign_d = 1'b0;
               memReq_d   = 1'b0;
               memWe_d    = 1'b0;
               memAddr_d  = '0;
               memWdata_d = '0;
               memBe_d    = '0;
               if (!isStore_q) begin
                  rdata_d = loadExt;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         isStore_q  <= 1'b0;
         addrLow_q  <= '0;
         funct3_q   <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         memReq_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         memBe_q    <= '0;
      end else begin
         state_q    <= state_d;
         isStore_q  <= isStore_d;
         addrLow_q  <= addrLow_d;
         funct3_q   <= funct3_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         memReq_q   <= memReq_d;
         memWe_q    <= memWe_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
         memBe_q    <= memBe_d;
      end
   end

   // Stall must release in DONE so the core retires on that edge, and never assert under reset.
   assign stall_o     = !rst_i && (((state_q == IDLE) && start) || (state_q == REQ));
   assign done_o      = (state_q == DONE);
   assign rdata_o     = rdata_q;
   assign misalign_o  = misalign_q;
   assign mem_req_o   = memReq_q;
   assign mem_we_o    = memWe_q;
   assign mem_addr_o  = memAddr_q;
   assign mem_wdata_o = memWdata_q;
   assign mem_be_o    = memBe_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed accesses plus randomized ones checked against
// a behavioural model of lane selection and extension; honours LSU_MISALIGN_TRAP_EN if defined.

module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TrapOn = 1'b1;
`else
   localparam bit TrapOn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ldEn = 1'b0;
   logic        stEn = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        memAck = 1'b0;
   logic [31:0] memRdata = '0;

   logic [31:0] rdata;
   logic        done;
   logic        stall;
   logic        misalign;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [3:0]  memBe;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] expRdata = '0;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .ld_en_i     (ldEn),
      .st_en_i     (stEn),
      .funct3_i    (funct3),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .rdata_o     (rdata),
      .done_o      (done),
      .stall_o     (stall),
      .misalign_o  (misalign),
      .mem_req_o   (memReq),
      .mem_we_o    (memWe),
      .mem_addr_o  (memAddr),
      .mem_wdata_o (memWdata),
      .mem_be_o    (memBe),
      .mem_ack_i   (memAck),
      .mem_rdata_i (memRdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One complete access: starts just after a falling edge, ends just after the falling edge following DONE.
   task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] word, input int waits);
      int          size;
      int          idx;
      logic        isStore;
      logic        mis;
      logic [31:0] eBe;
      logic [31:0] eWd;
      logic [31:0] eRd;
      logic [31:0] eAddr;
      logic [31:0] v;

      isStore = st;
      size    = int'(f3[1:0]);
      idx     = int'(a % 4);
      eAddr   = a - (a % 4);
      mis     = (size == 1 && (a % 2) != 0) || (size >= 2 && idx != 0);
      eBe     = 32'd15;
      eWd     = '0;
      eRd     = word;
      if (isStore) begin
         if (size == 0) begin
            eBe = 32'd1 << idx;
            eWd = (wd & 32'hFF) * 32'h01010101;
         end else if (size == 1) begin
            eBe = 32'd3 << (2 * ((a / 2) % 2));
            eWd = (wd & 32'hFFFF) * 32'h00010001;
         end else begin
            eWd = wd;
         end
      end else begin
         if (size == 0) begin
            v = (word >> (8 * idx)) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v + 32'hFFFFFF00;
            eRd = v;
         end else if (size == 1) begin
            v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF0000;
            eRd = v;
         end
      end

      ldEn = ld; stEn = st; funct3 = f3; addr = a; wdata = wd;
      memAck = 1'b0; memRdata = $urandom;
      #1;
      checkOutput("stallStart", {31'd0, stall}, 32'd1);
      checkOutput("reqStart", {31'd0, memReq}, 32'd0);
      @(negedge clk);

      if (TrapOn && mis) begin
         #1;
         expRdata = '0;
         checkOutput("trapDone", {31'd0, done}, 32'd1);
         checkOutput("trapMisalign", {31'd0, misalign}, 32'd1);
         checkOutput("trapRdata", rdata, expRdata);
         checkOutput("trapNoReq", {31'd0, memReq}, 32'd0);
         checkOutput("trapStall", {31'd0, stall}, 32'd0);
         ldEn = 1'b0; stEn = 1'b0;
         @(negedge clk);
         #1;
         checkOutput("trapDoneOnce", {31'd0, done}, 32'd0);
         return;
      end

      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            memAck = 1'b1; memRdata = word;
         end else begin
            memRdata = $urandom;
         end
         #1;
         checkOutput("reqHigh", {31'd0, memReq}, 32'd1);
         checkOutput("reqWe", {31'd0, memWe}, {31'd0, isStore});
         checkOutput("reqAddr", memAddr, eAddr);
         checkOutput("reqBe", {28'd0, memBe}, eBe);
         if (isStore) checkOutput("reqWdata", memWdata, eWd);
         checkOutput("reqStall", {31'd0, stall}, 32'd1);
         checkOutput("reqNoDone", {31'd0, done}, 32'd0);
         @(negedge clk);
      end

      memAck = 1'b0; memRdata = $urandom;
      if (!isStore) expRdata = eRd;
      #1;
      checkOutput("doneHigh", {31'd0, done}, 32'd1);
      checkOutput("doneStall", {31'd0, stall}, 32'd0);
      checkOutput("doneReqLow", {31'd0, memReq}, 32'd0);
      checkOutput("doneWeLow", {31'd0, memWe}, 32'd0);
      checkOutput("doneAddrClr", memAddr, 32'd0);
      checkOutput("doneWdataClr", memWdata, 32'd0);
      checkOutput("doneBeClr", {28'd0, memBe}, 32'd0);
      checkOutput("doneMisalign", {31'd0, misalign}, 32'd0);
      checkOutput("doneRdata", rdata, expRdata);
      ldEn = 1'b0; stEn = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("doneOnce", {31'd0, done}, 32'd0);
      checkOutput("rdataHold", rdata, expRdata);
   endtask

   initial begin
      int          sel;
      logic [2:0]  rf3;
      logic [31:0] ra;

      // Reset values, with a pending request that must not raise stall.
      ldEn = 1'b1;
      #1;
      checkOutput("rstStall", {31'd0, stall}, 32'd0);
      checkOutput("rstDone", {31'd0, done}, 32'd0);
      checkOutput("rstRdata", rdata, 32'd0);
      checkOutput("rstMisalign", {31'd0, misalign}, 32'd0);
      checkOutput("rstReq", {31'd0, memReq}, 32'd0);
      checkOutput("rstWe", {31'd0, memWe}, 32'd0);
      checkOutput("rstAddr", memAddr, 32'd0);
      checkOutput("rstWdata", memWdata, 32'd0);
      checkOutput("rstBe", {28'd0, memBe}, 32'd0);
      ldEn = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("idleStall", {31'd0, stall}, 32'd0);

      applyStimulus(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h00A50000, 0);
      checkOutput("lbValue", expRdata, 32'hFFFFFFA5);
      applyStimulus(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 1);
      checkOutput("lhuValue", expRdata, 32'h00008001);
      applyStimulus(1'b0, 1'b1, 3'b000, 32'h203, 32'h12345678, 32'h0, 4);
      applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'hFFFFFFFF, 0);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 32'h13579BDF, 0);

      // Reset in the middle of a request, then a late acknowledge.
      ldEn = 1'b1; stEn = 1'b0; funct3 = 3'b010; addr = 32'h40;
      @(negedge clk);
      #1;
      checkOutput("midReqUp", {31'd0, memReq}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midRstReq", {31'd0, memReq}, 32'd0);
      checkOutput("midRstStall", {31'd0, stall}, 32'd0);
      ldEn = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      memAck = 1'b1;
      expRdata = '0;
      @(negedge clk);
      #1;
      checkOutput("lateAckDone", {31'd0, done}, 32'd0);
      checkOutput("lateAckReq", {31'd0, memReq}, 32'd0);
      @(negedge clk);
      #1;
      checkOutput("lateAckDone2", {31'd0, done}, 32'd0);
      checkOutput("lateAckStall", {31'd0, stall}, 32'd0);
      checkOutput("lateAckRdata", rdata, expRdata);
      memAck = 1'b0;

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 2);
         rf3 = 3'($urandom_range(0, 7));
         ra  = $urandom & 32'h0000FFFF;
         applyStimulus(sel != 1, sel != 0, rf3, ra, $urandom, $urandom, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the single-cycle datapath and the data-memory port. It consumes the LOAD/STORE decode (`ld_en`, `st_en` = `dmem_wr_en`), `funct3`, the ALU address and rs2, and drives a req/ack memory handshake. It returns the sign- or zero-extended load result to the `sel_res` = 0 writeback mux, and holds the core with `stall` until the access completes.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; fixed at 32, with 4 byte lanes
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `ld_en`  in  1  current instruction is LOAD
- `st_en`  in  1  current instruction is STORE (`dmem_wr_en`)
- `funct3`  in  3  access size and signedness
- `addr`  in  ADDR_W  byte address (ALU result)
- `wdata`  in  DATA_W  store data (rs2)
- `rdata`  out  DATA_W  extended load result, valid while `done`=1
- `done`  out  1  one-cycle completion pulse
- `stall`  out  1  freeze PC/register-file write (combinational)
- `misalign`  out  1  misaligned-access flag, valid with `done`
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  word-aligned address, bits [1:0] = 0
- `mem_wdata`  out  DATA_W  lane-replicated store data
- `mem_be`  out  4  byte enables
- `mem_ack`  in  1  memory accepted the request / read data valid
- `mem_rdata`  in  DATA_W  read word

## Operation
- FSM states:
  - IDLE (reset state)
  - REQ
  - DONE
- IDLE, when `st_en` or `ld_en` is high:
  - register `addr`, `funct3`, `wdata` and the access type.
  - go to REQ.
  - `st_en` takes priority if both inputs are high; the load is ignored.
- REQ:
  - `mem_req`=1; `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` are held stable.
  - Stay in REQ until `mem_ack`=1, then go to DONE.
  - On a load ack, register the extended `mem_rdata` into `rdata`.
- DONE:
  - `done`=1 for exactly one cycle, `stall`=0.
  - The core retires the instruction on this edge.
  - Next state is IDLE unconditionally, even if `ld_en`/`st_en` is still high in DONE.
- `stall` = !`rst` && ((IDLE && (`ld_en`||`st_en`)) || REQ).
- Size is `funct3[1:0]`: 00 byte, 01 half, 10 word, 11 treated as word. `funct3[2]`=1 selects zero-extension (LBU/LHU).
- Store lanes:
  - byte: `mem_be` = 4'b0001<<`addr[1:0]`; `mem_wdata` = the byte replicated ×4.
  - half: `mem_be` = 4'b0011<<{`addr[1]`,0}; `mem_wdata` = the half replicated ×2.
  - word: `mem_be` = 4'b1111.
- Load: `mem_be` = 4'b1111. The selected byte or half is extracted by `addr[1:0]` and sign- or zero-extended to 32 bits.
- `mem_ack` in IDLE or DONE is ignored.

## Timing
- Reset values (all outputs): `rdata`=0, `done`=0, `misalign`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0. `stall`=0 while `rst`=1.
- Reset mid-access: return to IDLE immediately and drop `mem_req` asynchronously. A late `mem_ack` is ignored.
- `mem_req` is registered and rises the cycle after IDLE detects the access.
- Minimum latency is 3 cycles (IDLE→REQ→DONE) when `mem_ack` is asserted in the first REQ cycle. Each extra wait cycle adds one cycle.
- `rdata` and `misalign` hold their values from DONE until the next DONE or reset.
- `mem_*` outputs are cleared to 0 on entry to DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, issues no memory request.
  - The FSM goes IDLE→DONE directly, with `misalign`=1, `rdata`=0 and no write.
- Undefined:
  - No alignment check; offending low address bits are ignored within the lane rules above.
  - `misalign` is tied to 0.

## Test plan
- LB, `addr`=0x102, `mem_rdata`=0x00A50000, ack on first REQ cycle → `done` in cycle 3, `rdata`=0xFFFFFFA5, `stall` high for cycles 1–2.
- LHU, `addr`=0x102, `mem_rdata`=0x80010000 → `rdata`=0x00008001, `mem_addr`=0x100, `mem_be`=4'b1111.
- SB, `addr`=0x203, `wdata`=0x12345678, ack after 4 wait cycles → `mem_be`=4'b1000, `mem_wdata`=0x78787878, `mem_we`=1, all held stable for 5 REQ cycles; `done` fires once.
- `ld_en`=`st_en`=1, SW `addr`=0x10 → store performed, `mem_we`=1, `mem_be`=4'b1111, `rdata` unchanged.
- `rst` asserted during REQ, then `mem_ack`=1 after release → `mem_req` drops immediately, no `done`, FSM in IDLE.
- LW, `addr`=0x6: with `LSU_MISALIGN_TRAP_EN`, no `mem_req`, `done`+`misalign`=1 in cycle 2. Without the macro, `mem_addr`=0x4, and `misalign`=0.
